// File: rtl/lfsr_prbs_checker.sv
// -----------------------------------------------------------------------------
// lfsr_prbs_checker
//
// Receive-side PRBS checker. It self-synchronises a local Fibonacci LFSR to the
// incoming serial stream and declares lock. Once locked, the LFSR runs free as
// the reference, so received errors never corrupt it. The checker then flags and
// counts errored bits. Too many errors inside one window drop it back to search.
//
// Ports
//   clk_i        : clock, all logic on the rising edge
//   rst_i        : synchronous active-high reset, highest priority
//   valid_i      : data_i carries a bit this cycle (no backpressure)
//   data_i       : received serial bit
//   clear_i      : synchronous clear of err_count_o / bit_count_o
//   locked_o     : checker is in LOCKED
//   bit_err_o    : one-cycle pulse per errored bit while locked
//   err_count_o  : saturating count of errored bits while locked
//   bit_count_o  : saturating count of valid bits checked while locked
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module lfsr_prbs_checker #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] TAPS        = 4'b1100,
  parameter int               LOCK_COUNT  = 8,
  parameter int               WINDOW      = 32,
  parameter int               LOSS_THRESH = 4,
  parameter int               CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             data_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             bit_err_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] bit_count_o
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WBIT_W  = $clog2(WINDOW + 1);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WBIT_W-1:0]  WBIT_LAST  = WBIT_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_THRESH - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_lfsr;
  logic [FILL_W-1:0]    r_fill;
  logic [MATCH_W-1:0]   r_match_cnt;
  logic [WBIT_W-1:0]    r_win_bits;
  logic [WERR_W-1:0]    r_win_err;
  logic                 r_bit_err;
  logic [CNT_W-1:0]     r_err_count;
  logic [CNT_W-1:0]     r_bit_count;

  logic w_pred;
  logic w_mismatch;
  logic w_fill_done;
  logic w_lock_hit;
  logic w_count_bit;
  logic w_count_err;
  logic w_loss;
  logic w_win_roll;

  assign w_pred      = ^(r_lfsr & TAPS);
  assign w_mismatch  = data_i ^ w_pred;
  assign w_fill_done = (r_fill == FILL_FULL);

  // An all-zero register predicts zero forever, so a match there proves nothing.
  assign w_lock_hit  = valid_i && (r_state == SEARCH) && w_fill_done && !w_mismatch &&
                       (r_lfsr != '0) && (r_match_cnt == MATCH_LAST);

  assign w_count_bit = valid_i && (r_state == LOCKED);
  assign w_count_err = w_count_bit && w_mismatch;
  assign w_loss      = w_count_err && (r_win_err == WERR_LAST);
  assign w_win_roll  = w_count_bit && (r_win_bits == WBIT_LAST);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= SEARCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SEARCH:  if (w_lock_hit) w_next_state = LOCKED;
      LOCKED:  if (w_loss)     w_next_state = SEARCH;
      default: w_next_state = SEARCH;
    endcase
  end

  // Outputs: all driven straight from registers.
  always_comb begin
    locked_o    = (r_state == LOCKED);
    bit_err_o   = r_bit_err;
    err_count_o = r_err_count;
    bit_count_o = r_bit_count;
  end

  // LFSR, acquisition and loss-window datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lfsr      <= '0;
      r_fill      <= '0;
      r_match_cnt <= '0;
      r_win_bits  <= '0;
      r_win_err   <= '0;
      r_bit_err   <= 1'b0;
    end else begin
      r_bit_err <= w_count_err;
      if (valid_i) begin
        if (r_state == SEARCH) begin
          // Load the received bit so the register tracks the transmitter.
          r_lfsr <= {r_lfsr[WIDTH-2:0], data_i};
          if (!w_fill_done) begin
            r_fill <= r_fill + FILL_W'(1);
          end else if (w_lock_hit) begin
            r_match_cnt <= '0;
            r_win_bits  <= '0;
            r_win_err   <= '0;
          end else if (!w_mismatch && (r_lfsr != '0)) begin
            r_match_cnt <= r_match_cnt + MATCH_W'(1);
          end else begin
            r_match_cnt <= '0;
          end
        end else begin
          // Free-running reference: feed back the prediction, never data_i.
          r_lfsr <= {r_lfsr[WIDTH-2:0], w_pred};
          if (w_loss) begin
            // Loss wins over a rollover landing on the same bit.
            r_fill      <= '0;
            r_match_cnt <= '0;
            r_win_bits  <= '0;
            r_win_err   <= '0;
          end else if (w_win_roll) begin
            r_win_bits <= '0;
            r_win_err  <= '0;
          end else begin
            r_win_bits <= r_win_bits + WBIT_W'(1);
            if (w_mismatch) r_win_err <= r_win_err + WERR_W'(1);
          end
        end
      end
    end
  end

  // Measurement counters. Clear wins over increment, but a bit counted on the
  // clearing cycle is kept, so the counter loads 1 instead of 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_count <= '0;
      r_bit_count <= '0;
    end else if (clear_i) begin
      r_bit_count <= CNT_W'(w_count_bit);
      r_err_count <= CNT_W'(w_count_err);
    end else begin
      if (w_count_bit && (r_bit_count != CNT_MAX)) r_bit_count <= r_bit_count + CNT_W'(1);
      if (w_count_err && (r_err_count != CNT_MAX)) r_err_count <= r_err_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/lfsr_prbs_checker.md
Name: lfsr_prbs_checker

Overview:
- Receive-side companion to the team's LFSR PRBS generator.
- Consumes a serial bit stream and self-synchronises a local Fibonacci LFSR to it.
- Declares lock, then flags and counts bit errors against a free-running reference.
- Loss-of-lock detection, counters clearable for BER measurement.

Parameters:
- WIDTH, 4: LFSR length in bits.
- TAPS, 4'b1100: feedback mask (x^4+x^3+1, period 15).
- LOCK_COUNT, 8: consecutive correct predictions needed to lock.
- WINDOW, 32: valid bits per loss-detection window.
- LOSS_THRESH, 4: errors within one window that force loss of lock.
- CNT_W, 16: width of the error and bit counters.

Ports:
- clk_i, input, 1: clock; all logic on rising edge.
- rst_i, input, 1: synchronous active-high reset.
- valid_i, input, 1: data_i is valid this cycle. No backpressure.
- data_i, input, 1: received serial bit.
- clear_i, input, 1: synchronous clear of err_count_o and bit_count_o.
- locked_o, output, 1: checker is in LOCKED.
- bit_err_o, output, 1: one-cycle pulse per errored bit while locked.
- err_count_o, output, CNT_W: saturating count of errored bits while locked.
- bit_count_o, output, CNT_W: saturating count of valid bits checked while locked.

Behaviour:
- Reset:
  - All outputs 0, state SEARCH.
  - LFSR state 0; fill, match, window-bit and window-error counters 0.
  - Reset has priority over everything and aborts any operation.
- Prediction: pred = ^(state & TAPS). All updates occur only on cycles with valid_i=1; with valid_i=0 all internal state holds and bit_err_o=0.
- SEARCH:
  - Always shift: state <= {state[WIDTH-2:0], data_i}.
  - While fill < WIDTH: fill++, no comparison.
  - When fill = WIDTH, compare data_i to pred:
    - Match with state != 0: match_cnt++.
    - Mismatch, or state == 0: match_cnt <= 0. An all-zero stream never locks.
  - When the LOCK_COUNT-th consecutive match is sampled: go to LOCKED, locked_o=1 on the next cycle, clear window counters.
  - No bit_err_o and no counting in SEARCH.
- LOCKED:
  - Free-running: state <= {state[WIDTH-2:0], pred}. Received errors never corrupt the reference.
  - Per valid bit: bit_count_o++ (saturating).
  - On mismatch: bit_err_o=1 the next cycle for exactly one cycle; err_count_o++ (saturating at all-ones); win_err++.
  - win_bits++; when WINDOW bits have been processed, win_bits and win_err reset to 0.
  - When win_err reaches LOSS_THRESH: go to SEARCH with fill=0 and match_cnt=0; locked_o=0 on the next cycle.
  - Loss takes precedence over a window rollover in the same cycle.
  - The errored bit that triggers loss is still counted and pulsed.
- clear_i:
  - Zeroes err_count_o and bit_count_o; has priority over increments.
  - If a bit is counted in the same cycle, the counter loads 1 instead of 0.
  - Does not affect lock state or window counters.
- Latency: all outputs registered, reflecting the valid bit sampled on the previous edge.
- Counters saturate; no wrap-around.

Test Plan:
- Reset: hold rst_i 3 cycles mid-stream -> all outputs 0, state SEARCH; prior lock lost.
- Clean PRBS (seed 4'b0001, TAPS 4'b1100, valid_i=1 every cycle):
  - Bits 1-4 fill; bits 5-12 match; locked_o rises the cycle after bit 12.
  - Over 100 further bits: err_count_o=0, bit_count_o=100, bit_err_o never asserted.
- Single flipped bit while locked:
  - Exactly one bit_err_o pulse; err_count_o=1.
  - Following bits report no errors; locked_o stays 1.
- All-zero stream for 200 bits -> locked_o never asserts.
- Loss and relock:
  - 4 flipped bits within 32 bits -> err_count_o=4, locked_o falls the cycle after the 4th error.
  - Clean stream then relocks after 12 valid bits.
  - 3 errors spread across separate windows -> lock held.
- valid_i toggling 1/0 with clear_i:
  - Lock timing counts valid bits only.
  - clear_i on an errored bit -> err_count_o=1.
  - With CNT_W=4, 20 errors spread across windows -> err_count_o holds 15.
